// File: rtl/mem_stage.sv
// mem_stage: memory-access stage ahead of write-back.
// Issues loads/stores on a req/gnt/rvalid data bus, stalls the pipeline while
// the access is in flight, and registers the aligned, extended load result.
// Optional response timeout: define DBUS_TIMEOUT_EN.
module mem_stage #(
  parameter int N            = 32,
  parameter int RESP_TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [2:0]   funct3,
  input  logic [N-1:0] alu_out,
  input  logic [N-1:0] store_data,
  output logic         stall,
  output logic         misalign,
  output logic [N-1:0] mem_out,
  output logic         dbus_req,
  output logic         dbus_we,
  output logic [N-1:0] dbus_addr,
  output logic [3:0]   dbus_be,
  output logic [N-1:0] dbus_wdata,
  input  logic         dbus_gnt,
  input  logic         dbus_rvalid,
  input  logic [N-1:0] dbus_rdata,
  output logic         bus_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t       state_q, state_d;
  logic [N-1:0] mem_out_q, mem_out_d;
  logic         timeout;

  logic       is_write;
  logic       is_read;
  logic       access;
  logic [1:0] lane;
  logic [1:0] size;
  logic       aligned;

  // Pick the byte/half selected by the address and sign- or zero-extend it.
  function automatic logic [N-1:0] fmt_load(input logic [2:0]   f3,
                                             input logic [1:0]   ln,
                                             input logic [N-1:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*ln +: 8];
    h = ln[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  fmt_load = {{(N-8){b[7]}}, b};
      3'b001:  fmt_load = {{(N-16){h[15]}}, h};
      3'b100:  fmt_load = {{(N-8){1'b0}}, b};
      3'b101:  fmt_load = {{(N-16){1'b0}}, h};
      default: fmt_load = w;
    endcase
  endfunction

  // Decode access type, size and alignment; store wins over load.
  always_comb begin
    is_write = mem_write;
    is_read  = mem_read & ~mem_write;
    access   = mem_read | mem_write;
    lane     = alu_out[1:0];
    size     = funct3[1:0];
    case (size)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~alu_out[0];
      default: aligned = (alu_out[1:0] == 2'b00);
    endcase
  end

  // Bus request fields track the (stalled, hence stable) instruction inputs.
  always_comb begin
    dbus_we   = is_write;
    dbus_addr = {alu_out[N-1:2], 2'b00};
    case (size)
      2'b00: begin
        dbus_be    = 4'b0001 << lane;
        dbus_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        dbus_be    = alu_out[1] ? 4'b1100 : 4'b0011;
        dbus_wdata = {2{store_data[15:0]}};
      end
      default: begin
        dbus_be    = 4'b1111;
        dbus_wdata = store_data;
      end
    endcase
  end

  // Next-state, stall/request outputs and load-result capture.
  always_comb begin
    state_d   = state_q;
    mem_out_d = mem_out_q;
    stall     = 1'b0;
    dbus_req  = 1'b0;
    misalign  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access) begin
          if (aligned) begin
            stall   = 1'b1;
            state_d = S_REQ;
          end else begin
            misalign = 1'b1;
          end
        end
      end
      S_REQ: begin
        dbus_req = 1'b1;
        stall    = 1'b1;
        if (dbus_gnt) begin
          if (is_write) begin
            state_d = S_DONE;
          end else if (dbus_rvalid) begin
            mem_out_d = fmt_load(funct3, lane, dbus_rdata);
            state_d   = S_DONE;
          end else begin
            state_d = S_WAIT;
          end
        end else if (timeout) begin
          state_d = S_DONE;
          if (is_read) mem_out_d = '0;
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (dbus_rvalid) begin
          mem_out_d = fmt_load(funct3, lane, dbus_rdata);
          state_d   = S_DONE;
        end else if (timeout) begin
          state_d = S_DONE;
          if (is_read) mem_out_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered load result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mem_out_q <= '0;
    end else begin
      state_q   <= state_d;
      mem_out_q <= mem_out_d;
    end
  end

  assign mem_out = mem_out_q;

`ifdef DBUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(RESP_TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_err_q, bus_err_d;
  logic             busy;

  // Count cycles spent in REQ/WAIT; the last counted cycle forces DONE.
  always_comb begin
    busy      = (state_q == S_REQ) || (state_q == S_WAIT);
    timeout   = busy && (cnt_q == CNT_W'(RESP_TIMEOUT - 1));
    cnt_d     = busy ? cnt_q + 1'b1 : '0;
    bus_err_d = bus_err_q |
                (timeout && (((state_q == S_REQ) && !dbus_gnt) ||
                             ((state_q == S_WAIT) && !dbus_rvalid)));
  end

  // Timeout counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign bus_err = bus_err_q;
`else
  assign timeout = 1'b0;
  assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: loads (with/without WAIT), stores with
// delayed grant, misaligned drops, reset during WAIT, optional timeout.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] alu_out, store_data;
  logic        stall, misalign;
  logic [31:0] mem_out;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic        dbus_gnt, dbus_rvalid;
  logic [31:0] dbus_rdata;
  logic        bus_err;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_stage #(.N(32), .RESP_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .alu_out(alu_out), .store_data(store_data),
    .stall(stall), .misalign(misalign), .mem_out(mem_out),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_be(dbus_be), .dbus_wdata(dbus_wdata),
    .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata),
    .bus_err(bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Load: IDLE -> REQ (gnt) -> [WAIT (rvalid)] -> DONE.
  task automatic do_load(input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rd, input logic [31:0] exp, input bit same);
    @(negedge clk);
    mem_read = 1'b1; mem_write = 1'b0; funct3 = f3; alu_out = addr;
    #1 chk("ld_idle_stall", {31'd0, stall}, 32'd1);
    chk("ld_idle_req", {31'd0, dbus_req}, 32'd0);
    @(negedge clk);
    #1 chk("ld_req", {31'd0, dbus_req}, 32'd1);
    chk("ld_req_stall", {31'd0, stall}, 32'd1);
    chk("ld_addr", dbus_addr, {addr[31:2], 2'b00});
    chk("ld_we", {31'd0, dbus_we}, 32'd0);
    dbus_gnt = 1'b1;
    if (same) begin
      dbus_rvalid = 1'b1; dbus_rdata = rd;
    end else begin
      @(negedge clk);
      dbus_gnt = 1'b0;
      #1 chk("ld_wait_stall", {31'd0, stall}, 32'd1);
      chk("ld_wait_req", {31'd0, dbus_req}, 32'd0);
      dbus_rvalid = 1'b1; dbus_rdata = rd;
    end
    @(negedge clk);
    dbus_gnt = 1'b0; dbus_rvalid = 1'b0; mem_read = 1'b0;
    #1 chk("ld_done_stall", {31'd0, stall}, 32'd0);
    chk("ld_done_req", {31'd0, dbus_req}, 32'd0);
    chk("ld_mem_out", mem_out, exp);
  endtask

  // Store with gnt withheld for 'dly' REQ cycles.
  task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] sd,
                          input logic [3:0] be, input logic [31:0] wd, input int dly,
                          input logic also_rd);
    @(negedge clk);
    mem_write = 1'b1; mem_read = also_rd; funct3 = f3; alu_out = addr; store_data = sd;
    #1 chk("st_idle_stall", {31'd0, stall}, 32'd1);
    for (int i = 0; i <= dly; i++) begin
      @(negedge clk);
      #1 chk("st_req", {31'd0, dbus_req}, 32'd1);
      chk("st_stall", {31'd0, stall}, 32'd1);
      chk("st_we", {31'd0, dbus_we}, 32'd1);
      chk("st_be", {28'd0, dbus_be}, {28'd0, be});
      chk("st_wdata", dbus_wdata, wd);
      chk("st_addr", dbus_addr, {addr[31:2], 2'b00});
    end
    dbus_gnt = 1'b1;
    @(negedge clk);
    dbus_gnt = 1'b0; mem_write = 1'b0; mem_read = 1'b0;
    #1 chk("st_done_stall", {31'd0, stall}, 32'd0);
    chk("st_done_req", {31'd0, dbus_req}, 32'd0);
  endtask

  // Misaligned access: dropped in IDLE for one cycle.
  task automatic do_misalign(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] held);
    @(negedge clk);
    mem_read = 1'b1; mem_write = 1'b0; funct3 = f3; alu_out = addr;
    #1 chk("mis_pulse", {31'd0, misalign}, 32'd1);
    chk("mis_stall", {31'd0, stall}, 32'd0);
    chk("mis_req", {31'd0, dbus_req}, 32'd0);
    @(negedge clk);
    mem_read = 1'b0;
    #1 chk("mis_clear", {31'd0, misalign}, 32'd0);
    chk("mis_req2", {31'd0, dbus_req}, 32'd0);
    chk("mis_mem_out", mem_out, held);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
    alu_out = '0; store_data = '0; dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_req", {31'd0, dbus_req}, 32'd0);
    chk("rst_misalign", {31'd0, misalign}, 32'd0);
    chk("rst_mem_out", mem_out, 32'd0);
    chk("rst_bus_err", {31'd0, bus_err}, 32'd0);

    do_load(3'b000, 32'h0000_1003, 32'h80FF_1234, 32'hFFFF_FF80, 1'b0); // LB
    do_load(3'b101, 32'h0000_2002, 32'hBEEF_0000, 32'h0000_BEEF, 1'b1); // LHU
    do_store(3'b000, 32'h0000_3001, 32'h0000_00A5, 4'b0010, 32'hA5A5_A5A5, 3, 1'b0); // SB
    chk("st_keeps_mem_out", mem_out, 32'h0000_BEEF);
    do_store(3'b001, 32'h0000_5002, 32'h1234_ABCD, 4'b1100, 32'hABCD_ABCD, 0, 1'b0); // SH
    do_store(3'b010, 32'h0000_6004, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 1, 1'b1); // SW, write wins
    do_load(3'b001, 32'h0000_7002, 32'h8001_5555, 32'hFFFF_8001, 1'b0); // LH
    do_load(3'b100, 32'h0000_7001, 32'h0000_C300, 32'h0000_00C3, 1'b1); // LBU
    do_load(3'b010, 32'h0000_7008, 32'h1357_2468, 32'h1357_2468, 1'b1); // LW
    do_misalign(3'b010, 32'h0000_4002, 32'h1357_2468);                  // LW misaligned
    do_misalign(3'b001, 32'h0000_4001, 32'h1357_2468);                  // LH misaligned
    chk("bus_err_idle", {31'd0, bus_err}, 32'd0);

`ifdef DBUS_TIMEOUT_EN
    // Read granted, rvalid never returns: REQ + 3 WAIT cycles, then DONE.
    @(negedge clk);
    mem_read = 1'b1; funct3 = 3'b010; alu_out = 32'h0000_9000;
    @(negedge clk);
    #1 chk("to_req", {31'd0, dbus_req}, 32'd1);
    dbus_gnt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      dbus_gnt = 1'b0;
      #1 chk("to_wait_stall", {31'd0, stall}, 32'd1);
      chk("to_no_err_yet", {31'd0, bus_err}, 32'd0);
    end
    @(negedge clk);
    mem_read = 1'b0;
    #1 chk("to_done_stall", {31'd0, stall}, 32'd0);
    chk("to_bus_err", {31'd0, bus_err}, 32'd1);
    chk("to_mem_out", mem_out, 32'd0);
    @(negedge clk);
    #1 chk("to_bus_err_sticky", {31'd0, bus_err}, 32'd1);
`endif

    // Reset while in WAIT, then a stray rvalid.
    @(negedge clk);
    mem_read = 1'b1; funct3 = 3'b010; alu_out = 32'h0000_8000;
    @(negedge clk);
    dbus_gnt = 1'b1;
    @(negedge clk);
    dbus_gnt = 1'b0;
    #1 chk("rw_wait_stall", {31'd0, stall}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; mem_read = 1'b0; dbus_rvalid = 1'b1; dbus_rdata = 32'h1234_5678;
    #1 chk("rw_stall", {31'd0, stall}, 32'd0);
    chk("rw_req", {31'd0, dbus_req}, 32'd0);
    chk("rw_mem_out", mem_out, 32'd0);
    chk("rw_bus_err", {31'd0, bus_err}, 32'd0);
    @(negedge clk);
    dbus_rvalid = 1'b0;
    #1 chk("rw_no_capture", mem_out, 32'd0);
    chk("rw_stall2", {31'd0, stall}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
